// File: rtl/dda_pkg.sv
// dda_pkg: shared definitions for the DDA map-read path.
//   MAP_OOB_WALL  : cell value returned for out-of-range map reads
//   map_tag_t     : per-read tracking record {valid, tag, oob}
//   map_addr_w()  : map address width for an N x N map
//   map_tag_w()   : owner-tag width for a given core count
package dda_pkg;

  localparam logic [3:0] MAP_OOB_WALL = 4'hF;

  // The tag field is sized for the largest supported core count so the
  // record can be shared by modules with different NUM_CORES.
  localparam int MAP_TAG_MAX_W = 8;

  typedef struct packed {
    logic                     valid;
    logic [MAP_TAG_MAX_W-1:0] tag;
    logic                     oob;
  } map_tag_t;

  function automatic int map_addr_w(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  function automatic int map_tag_w(input int cores);
    return (cores > 1) ? $clog2(cores) : 1;
  endfunction

endpackage

// File: rtl/dda_map_arbiter_if.sv
// dda_map_arbiter_if: groups the core request bus and the BROM read port.
//   req_in / addr_in      : per-core level request and map address
//   bram_addr_out         : BROM read address
//   bram_data_in          : BROM read data
//   map_data_out          : returned cell value (broadcast)
//   map_data_valid_out    : one-hot return strobe
//   busy_out              : any read outstanding
// Modport slave is the arbiter; master is the cores + BROM side.
interface dda_map_arbiter_if #(
  parameter int N         = 24,
  parameter int NUM_CORES = 4
);
  import dda_pkg::*;

  localparam int ADDR_W = map_addr_w(N);

  logic [NUM_CORES-1:0]             req_in;
  logic [NUM_CORES-1:0][ADDR_W-1:0] addr_in;
  logic [ADDR_W-1:0]                bram_addr_out;
  logic [3:0]                       bram_data_in;
  logic [3:0]                       map_data_out;
  logic [NUM_CORES-1:0]             map_data_valid_out;
  logic                             busy_out;

  modport slave (
    input  req_in, addr_in, bram_data_in,
    output bram_addr_out, map_data_out, map_data_valid_out, busy_out
  );

  modport master (
    output req_in, addr_in, bram_data_in,
    input  bram_addr_out, map_data_out, map_data_valid_out, busy_out
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   elig_in      : eligible requesters
//   ptr_in       : index where the search starts (wraps modulo NUM_CORES)
//   grant_oh_out : one-hot winner
//   grant_idx_out: winner index
//   grant_any_out: a winner exists
module rr_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] elig_in,
  input  logic [IDX_W-1:0]     ptr_in,
  output logic [NUM_CORES-1:0] grant_oh_out,
  output logic [IDX_W-1:0]     grant_idx_out,
  output logic                 grant_any_out
);

  int unsigned c;

  always_comb begin
    grant_oh_out  = '0;
    grant_idx_out = '0;
    grant_any_out = 1'b0;
    c             = 0;
    for (int off = 0; off < NUM_CORES; off++) begin
      c = (int'(ptr_in) + off) % NUM_CORES;
      if (!grant_any_out && elig_in[c]) begin
        grant_any_out   = 1'b1;
        grant_idx_out   = IDX_W'(c);
        grant_oh_out[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dda_map_arbiter.sv
// dda_map_arbiter: shares one map BROM read port among NUM_CORES DDA cores.
//   pixel_clk_in : clock
//   rst_in       : asynchronous active-high reset
//   bus          : request bus + BROM port (see dda_map_arbiter_if)
// One read may be issued per cycle; each read's owner rides a tag pipeline
// alongside the BROM latency and the data is returned with a one-hot strobe.
module dda_map_arbiter
  import dda_pkg::*;
#(
  parameter int N            = 24,
  parameter int NUM_CORES    = 4,
  parameter int BRAM_LATENCY = 2
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  dda_map_arbiter_if.slave  bus
);

  localparam int ADDR_W = map_addr_w(N);
  localparam int TAG_W  = map_tag_w(NUM_CORES);
  localparam logic [ADDR_W:0] CELLS = (ADDR_W + 1)'(N * N);

  logic [NUM_CORES-1:0] pending;
  logic [NUM_CORES-1:0] pending_nxt;
  logic [NUM_CORES-1:0] elig;
  logic [NUM_CORES-1:0] grant_oh;
  logic [NUM_CORES-1:0] ret_oh;
  logic [TAG_W-1:0]     grant_idx;
  logic                 grant_any;
  logic [TAG_W-1:0]     rr_ptr;
  logic [TAG_W-1:0]     rr_ptr_nxt;
  map_tag_t             push;
  map_tag_t             ret;

  // Entry 0 is registered together with bram_addr_out; entry BRAM_LATENCY
  // therefore lines up with bram_data_in for the same read.
  map_tag_t tag_pipe [0:BRAM_LATENCY];

  // Blocking on the strobe keeps a core that is still dropping req_in
  // from being granted a second time.
  assign elig = bus.req_in & ~pending & ~bus.map_data_valid_out;

  rr_arbiter #(.NUM_CORES(NUM_CORES), .IDX_W(TAG_W)) u_rr (
    .elig_in       (elig),
    .ptr_in        (rr_ptr),
    .grant_oh_out  (grant_oh),
    .grant_idx_out (grant_idx),
    .grant_any_out (grant_any)
  );

  always_comb begin
    ret    = tag_pipe[BRAM_LATENCY];
    ret_oh = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (ret.valid && ret.tag == MAP_TAG_MAX_W'(i)) ret_oh[i] = 1'b1;
    end
    pending_nxt = (pending & ~ret_oh) | grant_oh;

    push.valid = grant_any;
    push.tag   = MAP_TAG_MAX_W'(grant_idx);
    push.oob   = grant_any && ({1'b0, bus.addr_in[grant_idx]} >= CELLS);

    rr_ptr_nxt = rr_ptr;
    if (grant_any) begin
      rr_ptr_nxt = (grant_idx == TAG_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      bus.bram_addr_out      <= '0;
      bus.map_data_out       <= '0;
      bus.map_data_valid_out <= '0;
      pending                <= '0;
      rr_ptr                 <= '0;
      for (int i = 0; i <= BRAM_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      pending <= pending_nxt;
      rr_ptr  <= rr_ptr_nxt;
      if (grant_any) bus.bram_addr_out <= bus.addr_in[grant_idx];

      tag_pipe[0] <= push;
      for (int i = 1; i <= BRAM_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];

      bus.map_data_valid_out <= ret_oh;
      // Out-of-range reads come back as a wall so the DDA terminates.
      if (ret.valid) bus.map_data_out <= ret.oob ? MAP_OOB_WALL : bus.bram_data_in;
    end
  end

  assign bus.busy_out = |pending;

endmodule

// File: tb/tb_dda_map_arbiter.sv
// tb_dda_map_arbiter: scoreboard bench for dda_map_arbiter (N=24, 4 cores,
// BROM latency 2). Expected returns are queued when requests are driven and
// matched against the one-hot strobe as it appears.
module tb_dda_map_arbiter;

  localparam int N   = 24;
  localparam int NC  = 4;
  localparam int LAT = 2;
  localparam int AW  = 10;

  typedef struct {
    int         due;
    logic [3:0] oh;
    logic [3:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   c0;
  logic auto_drop;
  logic [NC-1:0] last_valid = '0;
  logic [3:0]    brom_d1 = '0;
  exp_t q[$];
  exp_t mon_e;

  dda_map_arbiter_if #(.N(N), .NUM_CORES(NC)) bus ();

  dda_map_arbiter #(.N(N), .NUM_CORES(NC), .BRAM_LATENCY(LAT)) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] brom_val(input logic [AW-1:0] a);
    return 4'(a % 11);
  endfunction

  // BROM model: data appears LAT cycles after the address cycle.
  initial bus.bram_data_in = '0;
  always @(posedge clk) begin
    brom_d1          <= brom_val(bus.bram_addr_out);
    bus.bram_data_in <= brom_d1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    last_valid <= bus.map_data_valid_out;
    if (!rst) begin
      if (bus.map_data_valid_out != '0) begin
        if (q.size() == 0) begin
          check_val("unexpected_pulse", 32'(bus.map_data_valid_out), 32'd0);
        end else begin
          mon_e = q.pop_front();
          check_val("pulse_cycle", cyc, mon_e.due);
          check_val("pulse_core", 32'(bus.map_data_valid_out), 32'(mon_e.oh));
          check_val("pulse_data", 32'(bus.map_data_out), 32'(mon_e.data));
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        mon_e = q.pop_front();
        check_val("missing_pulse", 32'd0, 32'(mon_e.oh));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_drop) bus.req_in = bus.req_in & ~last_valid;
  endtask

  task automatic expect_ret(input int due, input logic [3:0] oh, input logic [3:0] data);
    exp_t e;
    e.due = due; e.oh = oh; e.data = data;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    if (q.size() != 0) begin
      check_val("drain_timeout", q.size(), 0);
      q.delete();
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    auto_drop = 1'b1;
    bus.req_in = '0;
    bus.addr_in = '0;
    repeat (3) tick();
    check_val("rst_bram_addr", 32'(bus.bram_addr_out), 0);
    check_val("rst_map_data", 32'(bus.map_data_out), 0);
    check_val("rst_valid", 32'(bus.map_data_valid_out), 0);
    check_val("rst_busy", 32'(bus.busy_out), 0);
    rst = 1'b0;
    tick();

    // all four cores at once: grants 0..3 back to back
    for (int k = 0; k < NC; k++) bus.addr_in[k] = AW'((k + 1) * 10);
    bus.req_in = 4'b1111;
    c0 = cyc;
    for (int k = 0; k < NC; k++) expect_ret(c0 + 4 + k, 4'(1 << k), brom_val(AW'((k + 1) * 10)));
    for (int k = 0; k < NC; k++) begin
      tick();
      check_val("all4_bram_addr", 32'(bus.bram_addr_out), (k + 1) * 10);
    end
    drain();

    // single core, latency and busy window
    bus.addr_in[0] = AW'(25);
    bus.req_in = 4'b0001;
    c0 = cyc;
    expect_ret(c0 + 4, 4'b0001, 4'd3);
    tick();
    check_val("single_bram_addr", 32'(bus.bram_addr_out), 25);
    check_val("single_busy_c1", 32'(bus.busy_out), 1);
    tick();
    check_val("single_busy_c2", 32'(bus.busy_out), 1);
    tick();
    check_val("single_busy_c3", 32'(bus.busy_out), 1);
    tick();
    check_val("single_busy_c4", 32'(bus.busy_out), 0);
    drain();

    // out-of-range address returns the wall value
    bus.addr_in[1] = AW'(576);
    bus.req_in = 4'b0010;
    c0 = cyc;
    expect_ret(c0 + 4, 4'b0010, 4'hF);
    tick();
    check_val("oob_bram_addr", 32'(bus.bram_addr_out), 576);
    drain();

    // core 3 holds req through its strobe: one read only
    bus.addr_in[3] = AW'(100);
    bus.req_in = 4'b1000;
    c0 = cyc;
    expect_ret(c0 + 4, 4'b1000, brom_val(AW'(100)));
    drain();
    repeat (6) tick();
    check_val("nodouble_busy", 32'(bus.busy_out), 0);

    // fairness: cores 0 and 2 requesting continuously
    auto_drop = 1'b0;
    bus.addr_in[0] = AW'(33);
    bus.addr_in[2] = AW'(47);
    bus.req_in = 4'b0101;
    c0 = cyc;
    for (int m = 0; m < 4; m++) begin
      expect_ret(c0 + 4 + 5 * m, 4'b0001, brom_val(AW'(33)));
      expect_ret(c0 + 5 + 5 * m, 4'b0100, brom_val(AW'(47)));
    end
    repeat (17) tick();
    bus.req_in = '0;
    auto_drop = 1'b1;
    drain();

    // reset mid-flight: nothing returns, pointer restarts at 0
    bus.addr_in[2] = AW'(60);
    bus.req_in = 4'b0100;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_val("midrst_bram_addr", 32'(bus.bram_addr_out), 0);
    check_val("midrst_map_data", 32'(bus.map_data_out), 0);
    check_val("midrst_valid", 32'(bus.map_data_valid_out), 0);
    check_val("midrst_busy", 32'(bus.busy_out), 0);
    bus.req_in = '0;
    tick();
    tick();
    rst = 1'b0;
    repeat (6) tick();
    bus.addr_in[1] = AW'(70);
    bus.addr_in[3] = AW'(80);
    bus.req_in = 4'b1010;
    c0 = cyc;
    expect_ret(c0 + 4, 4'b0010, brom_val(AW'(70)));
    expect_ret(c0 + 5, 4'b1000, brom_val(AW'(80)));
    drain();
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
